sor_right_pipe: RTL and testbench



---
 rtl/sor_right_pipe.sv | 125 ++++++++++++
 tb/tb_sor_right_pipe.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sor_right_pipe.sv
// sor_right_pipe
// Pipelined shift-right / rotate-right unit with a valid/ready handshake on
// both sides. Stage k applies one conditional right move of 2^k bit
// positions, so one operand can be accepted per clock. The result appears
// SEL_W cycles after acceptance.
//
// Build option:
//   SOR_RIGHT_ARITH_EN  when defined, shift mode fills vacated MSBs with the
//                       operand's original MSB (arithmetic shift). When
//                       undefined, shift mode zero-fills (logical shift).
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand present on data/select/control
//   in_ready   unit accepts the operand this cycle
//   data       operand, WIDTH bits
//   select     shift/rotate amount, SEL_W bits
//   control    0 = shift right, 1 = rotate right
//   out_valid  sor holds a result
//   out_ready  downstream accepts the result
//   sor        shifted/rotated result, driven from the last stage register
module sor_right_pipe #(
   parameter int WIDTH = 8,
   parameter int SEL_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] data,
   input  logic [SEL_W-1:0] select,
   input  logic             control,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sor
);

   logic advance;
   logic fill_in;

   // The fill bit is decided once at the input so that every later stage
   // fills with the operand's original MSB, not an already-shifted bit.
`ifdef SOR_RIGHT_ARITH_EN
   assign fill_in = data[WIDTH-1];
`else
   assign fill_in = 1'b0;
`endif

   // One global stall: the whole pipe moves only when the last stage is
   // empty or is being drained this cycle.
   assign in_ready = !out_valid || out_ready;
   assign advance  = in_ready;

   for (genvar k = 0; k < SEL_W; k++) begin : g_stage
      localparam int AMT = 1 << k;

      logic [WIDTH-1:0] src_data;
      logic [SEL_W-1:0] src_sel;
      logic             src_ctrl;
      logic             src_fill;
      logic             src_valid;
      logic [WIDTH-1:0] next_data;

      logic [WIDTH-1:0] data_q;
      logic [SEL_W-1:0] sel_q;
      logic             ctrl_q;
      logic             fill_q;
      logic             valid_q;

      if (k == 0) begin : g_first
         assign src_data  = data;
         assign src_sel   = select;
         assign src_ctrl  = control;
         assign src_fill  = fill_in;
         assign src_valid = in_valid;
      end else begin : g_rest
         assign src_data  = g_stage[k-1].data_q;
         assign src_sel   = g_stage[k-1].sel_q;
         assign src_ctrl  = g_stage[k-1].ctrl_q;
         assign src_fill  = g_stage[k-1].fill_q;
         assign src_valid = g_stage[k-1].valid_q;
      end

      // Conditional move by this stage's power of two: rotate wraps the low
      // bits to the top, shift brings in copies of the fill bit instead.
      always_comb begin
         next_data = src_data;
         if (src_sel[k]) begin
            if (src_ctrl) begin
               next_data = {src_data[AMT-1:0], src_data[WIDTH-1:AMT]};
            end else begin
               next_data = {{AMT{src_fill}}, src_data[WIDTH-1:AMT]};
            end
         end
      end

      // Stage register: holds while stalled, clears on reset so in-flight
      // operands are discarded and the output reads zero.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            data_q  <= '0;
            sel_q   <= '0;
            ctrl_q  <= 1'b0;
            fill_q  <= 1'b0;
            valid_q <= 1'b0;
         end else if (advance) begin
            data_q  <= next_data;
            sel_q   <= src_sel;
            ctrl_q  <= src_ctrl;
            fill_q  <= src_fill;
            valid_q <= src_valid;
         end
      end
   end

   assign out_valid = g_stage[SEL_W-1].valid_q;
   assign sor       = g_stage[SEL_W-1].data_q;

   // The last stage's sideband bits have no consumer beyond the pipe.
   logic unused_tail;
   assign unused_tail = ^{g_stage[SEL_W-1].sel_q, g_stage[SEL_W-1].ctrl_q,
                          g_stage[SEL_W-1].fill_q};

endmodule

// File: tb/tb_sor_right_pipe.sv
// tb_sor_right_pipe
// Self-checking bench for sor_right_pipe (WIDTH=8). A behavioural model
// computes each result with plain arithmetic at acceptance time and tracks
// when it must appear; a negedge process compares every cycle. Directed
// cases pin the model with hand-computed literals.
module tb_sor_right_pipe;

   localparam int WIDTH = 8;
   localparam int SEL_W = 3;
   localparam int LAT   = 3;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] data;
   logic [SEL_W-1:0] select;
   logic             control;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sor;

   int compared   = 0;
   int mismatched = 0;

   sor_right_pipe #(.WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .data      (data),
      .select    (select),
      .control   (control),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sor       (sor)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Expected result of one operand, straight from the arithmetic meaning of
   // shift/rotate right.
   function automatic logic [WIDTH-1:0] refSor(input logic [WIDTH-1:0] d,
                                               input int s, input logic c);
      logic [2*WIDTH-1:0] dbl;
      logic [WIDTH-1:0]   res;
      logic [WIDTH-1:0]   mask;
      if (c) begin
         dbl = {d, d} >> s;
         res = dbl[WIDTH-1:0];
      end else begin
         res  = d >> s;
         mask = ~(8'hFF >> s);
`ifdef SOR_RIGHT_ARITH_EN
         if (d[WIDTH-1]) res = res | mask;
`else
         if (mask == 8'hFF) res = res & 8'h00;
`endif
      end
      return res;
   endfunction

   task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual,
                              input logic [WIDTH-1:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
      end
   endtask

   // Model: result slots for the pipeline depth, advancing under the same
   // global-stall rule the unit promises. Checked every negedge.
   logic             m_valid [LAT];
   logic [WIDTH-1:0] m_res   [LAT];
   logic             m_adv;

   initial begin
      for (int i = 0; i < LAT; i++) begin
         m_valid[i] = 1'b0;
         m_res[i]   = '0;
      end
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            checkOutput("reset_out_valid", {7'd0, out_valid}, 8'd0);
            checkOutput("reset_sor", sor, 8'd0);
            for (int i = 0; i < LAT; i++) m_valid[i] = 1'b0;
         end else begin
            m_adv = !m_valid[LAT-1] || out_ready;
            checkOutput("model_out_valid", {7'd0, out_valid}, {7'd0, m_valid[LAT-1]});
            checkOutput("model_in_ready", {7'd0, in_ready}, {7'd0, m_adv});
            if (m_valid[LAT-1]) checkOutput("model_sor", sor, m_res[LAT-1]);
            if (m_adv) begin
               for (int i = LAT-1; i > 0; i--) begin
                  m_valid[i] = m_valid[i-1];
                  m_res[i]   = m_res[i-1];
               end
               m_valid[0] = in_valid;
               m_res[0]   = refSor(data, int'(select), control);
            end
         end
      end
   end

   // Present one operand from just after a rising edge and hold it until it
   // is accepted; returns at the same phase one edge after acceptance.
   task automatic applyStimulus(input logic [WIDTH-1:0] d, input logic [SEL_W-1:0] s,
                                input logic c);
      int guard;
      guard    = 0;
      data     = d;
      select   = s;
      control  = c;
      in_valid = 1'b1;
      while (!in_ready && guard < 50) begin
         @(posedge clk);
         #1;
         guard++;
      end
      if (guard >= 50) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL accept_timeout: in_ready stayed %b, expected 1", in_ready);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic waitCycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   logic [WIDTH-1:0] held;
   logic [2:0]       sv;

   initial begin
      rst_n     = 1'b1;
      in_valid  = 1'b0;
      data      = '0;
      select    = '0;
      control   = 1'b0;
      out_ready = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      checkOutput("por_out_valid", {7'd0, out_valid}, 8'd0);
      checkOutput("por_sor", sor, 8'd0);
      waitCycles(3);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("por_in_ready", {7'd0, in_ready}, 8'd1);

      // Single shift, latency and literal value.
      applyStimulus(8'b10100110, 3'b110, 1'b0);
      checkOutput("shift_lat1", {7'd0, out_valid}, 8'd0);
      waitCycles(1);
      checkOutput("shift_lat2", {7'd0, out_valid}, 8'd0);
      waitCycles(1);
      checkOutput("shift_valid", {7'd0, out_valid}, 8'd1);
`ifdef SOR_RIGHT_ARITH_EN
      checkOutput("shift_value", sor, 8'b11111110);
`else
      checkOutput("shift_value", sor, 8'b00000010);
`endif
      waitCycles(2);

      // Single rotate.
      applyStimulus(8'b10100110, 3'b110, 1'b1);
      waitCycles(2);
      checkOutput("rotate_value", sor, 8'b10011010);
      waitCycles(2);

      // select=0 passes the operand through.
      applyStimulus(8'b10000001, 3'b000, 1'b0);
      waitCycles(2);
      checkOutput("pass_value", sor, 8'b10000001);
      waitCycles(2);

      // Streaming: back-to-back, select 0..7, control alternating.
      for (int s = 0; s < 8; s++) begin
         sv = s[2:0];
         applyStimulus(8'b10000001, sv, sv[0]);
      end
      checkOutput("stream_s5_rot", sor, 8'b00001100);
      waitCycles(1);
      checkOutput("stream_s6_shift", sor, refSor(8'b10000001, 6, 1'b0));
      waitCycles(4);

      // Backpressure: fill the pipe with out_ready low, hold for 5 cycles.
      out_ready = 1'b0;
      applyStimulus(8'b11110000, 3'b001, 1'b1);
      applyStimulus(8'b11110000, 3'b100, 1'b0);
      applyStimulus(8'b00110101, 3'b011, 1'b1);
      waitCycles(1);
      held = sor;
      checkOutput("bp_first", held, 8'b01111000);
      for (int i = 0; i < 5; i++) begin
         checkOutput("bp_in_ready", {7'd0, in_ready}, 8'd0);
         checkOutput("bp_stable", sor, 8'b01111000);
         waitCycles(1);
      end
      out_ready = 1'b1;
      waitCycles(6);

      // Reset mid-stream with three operands in flight.
      applyStimulus(8'b01010101, 3'b001, 1'b1);
      applyStimulus(8'b01010101, 3'b010, 1'b0);
      applyStimulus(8'b01010101, 3'b011, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("rst_out_valid", {7'd0, out_valid}, 8'd0);
      checkOutput("rst_sor", sor, 8'd0);
      @(negedge clk);
      @(posedge clk);
      #3 rst_n = 1'b1;
      #1;
      checkOutput("rst_in_ready", {7'd0, in_ready}, 8'd1);
      for (int i = 0; i < 5; i++) begin
         waitCycles(1);
         checkOutput("rst_no_stale", {7'd0, out_valid}, 8'd0);
      end

      // Traffic after reset still works.
      applyStimulus(8'b10000000, 3'b111, 1'b0);
      waitCycles(2);
      checkOutput("post_rst_value", sor, refSor(8'b10000000, 7, 1'b0));
      waitCycles(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      compared++;
      mismatched++;
      $display("[TB] FAIL timeout: simulation time %0t, expected finish earlier", $time);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
